add_tree_reduce: RTL

- Fan-in counterpart of the fan-out adder pipeline. Accepts NUM_INPUTS parallel data lanes plus one valid bit per cycle, and produces their full-precision sum through a pipelined binary adder tree.
- Sits downstream of the multi-lane adder block and collapses its lane vector to one word.
- Built in the reset-reduction style: only the valid pipeline is reset; the data registers have no reset.

---
 rtl/add_tree_pkg.sv | 9 +
 rtl/valid_delay.sv | 20 ++
 rtl/add_tree_reduce.sv | 48 ++++
 3 files changed

// File: rtl/add_tree_pkg.sv
// add_tree_pkg: shared width and latency helpers for the adder-tree reducer and its bench
package add_tree_pkg;
  function automatic int out_width(input int data_width, input int num_inputs);
    return data_width + $clog2(num_inputs);
  endfunction
  function automatic int tree_latency(input int num_inputs);
    return $clog2(num_inputs) + 1;
  endfunction
endpackage

// File: rtl/valid_delay.sv
// valid_delay: reset-only shift register that delays a valid bit by CYCLES clocks
module valid_delay #(
  parameter int   CYCLES      = 1,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  output logic o_valid
);
  if (CYCLES == 0) begin : g_pass
    assign o_valid = i_valid;
  end else begin : g_sr
    logic [CYCLES-1:0] r_sr;
    always_ff @(posedge clk or posedge rst)
      if (rst) r_sr <= {CYCLES{RESET_VALUE}};
      else     r_sr <= CYCLES'({r_sr, i_valid});
    assign o_valid = r_sr[CYCLES-1];
  end
endmodule

// File: rtl/add_tree_reduce.sv
// add_tree_reduce: pipelined binary adder tree summing NUM_INPUTS unsigned lanes at full precision
module add_tree_reduce
  import add_tree_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_INPUTS = 4,
  localparam int OUT_WIDTH = out_width(DATA_WIDTH, NUM_INPUTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] in [NUM_INPUTS],
  output logic                  valid_out,
  output logic [OUT_WIDTH-1:0]  out
);
  localparam int LEVELS  = $clog2(NUM_INPUTS);
  localparam int LATENCY = tree_latency(NUM_INPUTS);
  localparam int PADDED  = 1 << LEVELS;
  logic [OUT_WIDTH-1:0] r_in [NUM_INPUTS];
  always_ff @(posedge clk)
    for (int j = 0; j < NUM_INPUTS; j++) r_in[j] <= OUT_WIDTH'(in[j]);
  // Level 0 is the registered lanes plus constant-zero padding up to a power of two.
  for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
    logic [OUT_WIDTH-1:0] w_node [PADDED>>k];
    if (k == 0) begin : g_leaf
      for (genvar j = 0; j < PADDED; j++) begin : g_pad
        if (j < NUM_INPUTS) begin : g_lane
          assign w_node[j] = r_in[j];
        end else begin : g_zero
          assign w_node[j] = '0;
        end
      end
    end else begin : g_sum
      logic [OUT_WIDTH-1:0] r_node [PADDED>>k];
      always_ff @(posedge clk)
        for (int j = 0; j < (PADDED >> k); j++)
          r_node[j] <= g_lvl[k-1].w_node[2*j] + g_lvl[k-1].w_node[2*j+1];
      assign w_node = r_node;
    end
  end
  assign out = g_lvl[LEVELS].w_node[0];
  valid_delay #(.CYCLES(LATENCY), .RESET_VALUE(1'b0)) u_valid (
    .clk     (clk),
    .rst     (rst),
    .i_valid (valid_in),
    .o_valid (valid_out)
  );
endmodule
